// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine and the debug blocks
// that reuse its state encoding.
//   NUM_REGS / ADDR_W / DATA_W : architectural register file geometry
//   dumpState_e                : dump FSM states (IDLE, REQ, READ, SEND, FIN)
//   nextIdx()                  : register index increment, modulo NUM_REGS
package regfile_dump_reader_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        READ = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } dumpState_e;

    // Explicit wrap so the increment stays correct if NUM_REGS is ever
    // not a power of two.
    function automatic logic [ADDR_W-1:0] nextIdx(input logic [ADDR_W-1:0] idx);
        if (idx == ADDR_W'(NUM_REGS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying one {index, data} record per dumped register.
//   out_valid : beat available (producer)
//   out_ready : beat accepted (consumer)
//   out_index : register index of the beat
//   out_data  : register value of the beat
//   out_last  : final beat of the requested range
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid/out_index/
// out_data/out_last stay stable until that transfer; out_ready may toggle
// freely and never depends combinationally on out_valid.
interface regfile_dump_reader_if;
    import regfile_dump_reader_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump_reader_range.sv
// Range walker for the dump engine: latches the requested first/last
// indices and steps the current index with modulo-NUM_REGS wrap.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture firstReg/lastReg, cur restarts at firstReg
//   firstReg  : first index of the range
//   lastReg   : last index of the range
//   advance   : step cur to the next index
//   cur       : current index
//   curNext   : index that follows cur
//   isLast    : cur is the last index of the range
module regfile_dump_reader_range
    import regfile_dump_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    input  logic              advance,
    output logic [ADDR_W-1:0] cur,
    output logic [ADDR_W-1:0] curNext,
    output logic              isLast
);

    logic [ADDR_W-1:0] lastLatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            lastLatch <= '0;
        end else if (load) begin
            cur       <= firstReg;
            lastLatch <= lastReg;
        end else if (advance) begin
            cur       <= nextIdx(cur);
        end
    end

    // Comparison against the latched end point makes first > last wrap
    // naturally, and first == last+1 walks all NUM_REGS entries.
    assign curNext = nextIdx(cur);
    assign isLast  = (cur == lastLatch);

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine. On start it stalls the core, takes over read
// port 1, walks the index range and emits one {index, data} beat per
// register, then releases the core once the final beat is accepted.
//   clk, rst        : clock, synchronous active-high reset
//   start           : dump request, honoured only in IDLE
//   first_reg       : first index to dump (latched on start)
//   last_reg        : last index to dump (latched on start)
//   busy            : engine active (any state but IDLE)
//   done            : one-cycle pulse after the final beat is accepted
//   core_stall_req  : request that the core freeze and yield the read port
//   core_stall_ack  : core frozen, read port owned by this block
//   rd_addr         : read index into register-file port 1
//   rd_data         : combinational read data from that port
//   outBus          : beat stream (master side)
//   dbgState        : current FSM state, for debug visibility
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first_reg,
    input  logic [ADDR_W-1:0]     last_reg,
    output logic                  busy,
    output logic                  done,
    output logic                  core_stall_req,
    input  logic                  core_stall_ack,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    regfile_dump_reader_if.master outBus,
    output dumpState_e            dbgState
);

    dumpState_e        state;
    logic              load;
    logic              advance;
    logic              beatTaken;
    logic              isLast;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] curNext;

    assign beatTaken = (state == SEND) && outBus.out_valid && outBus.out_ready;
    assign load      = (state == IDLE) && start;
    assign advance   = beatTaken && !outBus.out_last;
    assign dbgState  = state;

    regfile_dump_reader_range u_range (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .firstReg (first_reg),
        .lastReg  (last_reg),
        .advance  (advance),
        .cur      (cur),
        .curNext  (curNext),
        .isLast   (isLast)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            core_stall_req   <= 1'b0;
            rd_addr          <= '0;
            outBus.out_valid <= 1'b0;
            outBus.out_index <= '0;
            outBus.out_data  <= '0;
            outBus.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= REQ;
                        busy           <= 1'b1;
                        core_stall_req <= 1'b1;
                    end
                end
                REQ: begin
                    // rd_addr is only written on entry to READ so the
                    // register-file read is stable for the whole READ cycle.
                    if (core_stall_ack) begin
                        rd_addr <= cur;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (core_stall_ack) begin
                        outBus.out_valid <= 1'b1;
                        outBus.out_index <= cur;
                        outBus.out_data  <= rd_data;
                        outBus.out_last  <= isLast;
                        state            <= SEND;
                    end else begin
                        // Core let go of the port: re-request and retry cur.
                        state <= REQ;
                    end
                end
                SEND: begin
                    // Data is already captured, so stall_ack is not needed here.
                    if (beatTaken) begin
                        outBus.out_valid <= 1'b0;
                        if (outBus.out_last) begin
                            state          <= FIN;
                            done           <= 1'b1;
                            core_stall_req <= 1'b0;
                        end else begin
                            rd_addr <= curNext;
                            state   <= READ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register-file model on read port 1,
// hand-written timing / reset sequences, and a vector table of dump ranges
// checked against an expected-beat queue.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int EXP_W  = 1 + ADDR_W + DATA_W;
    localparam int BUDGET = 400;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic              busy;
    logic              done;
    logic              core_stall_req;
    logic              core_stall_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    dumpState_e        dbgState;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [EXP_W-1:0]  exp_q [$];

    int nChecks = 0;
    int nFails  = 0;

    regfile_dump_reader_if outBus ();

    regfile_dump_reader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .first_reg      (first_reg),
        .last_reg       (last_reg),
        .busy           (busy),
        .done           (done),
        .core_stall_req (core_stall_req),
        .core_stall_ack (core_stall_ack),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .outBus         (outBus),
        .dbgState       (dbgState)
    );

    // Register file read port: combinational read.
    assign rd_data = regs[rd_addr];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        int firstIdx;
        int lastIdx;
        int hold;      // cycles out_ready is held low on each beat
        int ackDelay;  // cycles core_stall_ack stays low after start
        int dropIdx;   // drop ack for one READ cycle of this index (-1: none)
        int spurAt;    // cycle to pulse a second start (-1: none)
        int expBeats;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic build_expected(input int f, input int l);
        int idx;
        exp_q.delete();
        idx = f;
        for (int k = 0; k < NUM_REGS; k++) begin
            exp_q.push_back({(idx == l) ? 1'b1 : 1'b0, ADDR_W'(idx), regs[idx]});
            if (idx == l) break;
            idx = (idx + 1) % NUM_REGS;
        end
    endtask

    task automatic run_dump(input int id, input vec_t v);
        int cyc, beats, doneCnt, holdCnt;
        bit dropped, dropPend, fin;
        logic [EXP_W-1:0] e;
        build_expected(v.firstIdx, v.lastIdx);
        @(negedge clk);
        start          = 1'b1;
        first_reg      = ADDR_W'(v.firstIdx);
        last_reg       = ADDR_W'(v.lastIdx);
        core_stall_ack = (v.ackDelay == 0);
        outBus.out_ready = (v.hold == 0);
        cyc = 0; beats = 0; doneCnt = 0; holdCnt = 0;
        dropped = 0; dropPend = 0; fin = 0;
        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == v.spurAt) begin
                start     = 1'b1;
                first_reg = 5'd9;
                last_reg  = 5'd9;
            end
            if (cyc <= v.ackDelay) begin
                check($sformatf("v%0d_no_beat_before_ack", id), outBus.out_valid, 1'b0);
                if (cyc == v.ackDelay) core_stall_ack = 1'b1;
            end
            if (dropPend) begin
                check($sformatf("v%0d_retry_state", id), dbgState, REQ);
                check($sformatf("v%0d_retry_no_beat", id), outBus.out_valid, 1'b0);
                core_stall_ack = 1'b1;
                dropPend = 0;
            end else if (!dropped && v.dropIdx >= 0 && dbgState == READ &&
                         rd_addr == ADDR_W'(v.dropIdx)) begin
                core_stall_ack = 1'b0;
                dropped  = 1;
                dropPend = 1;
            end
            if (outBus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_extra_beat_index", id), outBus.out_index, 64'hFFFF);
                end else begin
                    e = exp_q[0];
                    check($sformatf("v%0d_index", id), outBus.out_index, e[EXP_W-2 -: ADDR_W]);
                    check($sformatf("v%0d_data", id), outBus.out_data, e[DATA_W-1:0]);
                    check($sformatf("v%0d_last", id), outBus.out_last, e[EXP_W-1]);
                    if (holdCnt < v.hold) begin
                        outBus.out_ready = 1'b0;
                        holdCnt++;
                    end else begin
                        outBus.out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        beats++;
                        holdCnt = 0;
                    end
                end
            end else begin
                outBus.out_ready = (v.hold == 0);
            end
            if (done) begin
                doneCnt++;
                check($sformatf("v%0d_stall_req_at_done", id), core_stall_req, 1'b0);
                check($sformatf("v%0d_queue_empty_at_done", id), exp_q.size(), 0);
                fin = 1;
            end
        end
        check($sformatf("v%0d_finished_in_budget", id), fin, 1'b1);
        @(negedge clk);
        if (done) doneCnt++;
        check($sformatf("v%0d_busy_after", id), busy, 1'b0);
        check($sformatf("v%0d_done_pulses", id), doneCnt, 1);
        check($sformatf("v%0d_beats", id), beats, v.expBeats);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int doneSeen;
        rst = 1'b1;
        start = 1'b0;
        first_reg = '0;
        last_reg = '0;
        core_stall_ack = 1'b0;
        outBus.out_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i * 32'h11);
        regs[5] = 32'hDEADBEEF;

        vecs[0] = '{firstIdx: 5,  lastIdx: 5,  hold: 0, ackDelay: 0, dropIdx: -1, spurAt: -1, expBeats: 1};
        vecs[1] = '{firstIdx: 0,  lastIdx: 31, hold: 0, ackDelay: 0, dropIdx: -1, spurAt: -1, expBeats: 32};
        vecs[2] = '{firstIdx: 30, lastIdx: 1,  hold: 3, ackDelay: 0, dropIdx: -1, spurAt: -1, expBeats: 4};
        vecs[3] = '{firstIdx: 6,  lastIdx: 8,  hold: 0, ackDelay: 4, dropIdx: 7,  spurAt: -1, expBeats: 3};
        vecs[4] = '{firstIdx: 0,  lastIdx: 3,  hold: 0, ackDelay: 0, dropIdx: -1, spurAt: 6,  expBeats: 4};
        vecs[5] = '{firstIdx: 10, lastIdx: 9,  hold: 0, ackDelay: 0, dropIdx: -1, spurAt: -1, expBeats: 32};
        vecs[6] = '{firstIdx: 31, lastIdx: 0,  hold: 1, ackDelay: 2, dropIdx: -1, spurAt: -1, expBeats: 2};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stall_req", core_stall_req, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", outBus.out_valid, 1'b0);
        check("rst_out_index", outBus.out_index, 0);
        check("rst_out_data", outBus.out_data, 0);
        check("rst_out_last", outBus.out_last, 1'b0);
        check("rst_state", dbgState, IDLE);
        rst = 1'b0;

        // Single register, exact latency: start at edge 0.
        @(negedge clk);
        core_stall_ack = 1'b1;
        outBus.out_ready = 1'b1;
        start = 1'b1;
        first_reg = 5'd5;
        last_reg = 5'd5;
        @(negedge clk);
        start = 1'b0;
        check("lat_c1_busy", busy, 1'b1);
        check("lat_c1_stall_req", core_stall_req, 1'b1);
        check("lat_c1_state", dbgState, REQ);
        @(negedge clk);
        check("lat_c2_state", dbgState, READ);
        check("lat_c2_rd_addr", rd_addr, 5);
        check("lat_c2_no_valid", outBus.out_valid, 1'b0);
        @(negedge clk);
        check("lat_c3_valid", outBus.out_valid, 1'b1);
        check("lat_c3_index", outBus.out_index, 5);
        check("lat_c3_data", outBus.out_data, 32'hDEADBEEF);
        check("lat_c3_last", outBus.out_last, 1'b1);
        @(negedge clk);
        check("lat_c4_done", done, 1'b1);
        check("lat_c4_stall_req", core_stall_req, 1'b0);
        check("lat_c4_valid", outBus.out_valid, 1'b0);
        check("lat_c4_busy", busy, 1'b1);
        @(negedge clk);
        check("lat_c5_done", done, 1'b0);
        check("lat_c5_busy", busy, 1'b0);

        // Reset during SEND of the third beat of 0..31.
        start = 1'b1;
        first_reg = 5'd0;
        last_reg = 5'd31;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(outBus.out_valid && outBus.out_index == 5'd2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_rst_reached_beat3", (cyc < 50), 1'b1);
        check("mid_rst_state_send", dbgState, SEND);
        outBus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_stall_req", core_stall_req, 1'b0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_out_valid", outBus.out_valid, 1'b0);
        check("mid_rst_out_index", outBus.out_index, 0);
        check("mid_rst_out_data", outBus.out_data, 0);
        check("mid_rst_out_last", outBus.out_last, 1'b0);
        check("mid_rst_state", dbgState, IDLE);
        doneSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        check("mid_rst_no_done", doneSeen, 0);
        check("mid_rst_stays_idle", busy, 1'b0);

        // Table of ranges, including a fresh dump after the reset.
        for (int i = 0; i < 7; i++) begin
            run_dump(i, vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
